// File: rtl/cok_cevrimli_islemci.sv
// Multi-cycle RV32I integer core (no loads/stores): FETCH/EXEC sequencing with a
// fetch handshake, EBREAK halt, illegal-instruction/misaligned-target trap, retire counter.
module cok_cevrimli_islemci #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              OUT_REG  = 10,
    parameter int              CNT_W    = 32
) (
    input  logic                   saat,
    input  logic                   reset,
    output logic                   buyruk_istek,
    output logic [XLEN-1:0]        ps,
    input  logic [31:0]            buyruk,
    input  logic                   buyruk_gecerli,
    output logic signed [XLEN-1:0] yazmac_izle,
    output logic [CNT_W-1:0]       tamamlanan,
    output logic                   durdu,
    output logic                   hatali
);
    typedef enum logic [1:0] {FETCH, EXEC, DURDU, HATA} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [5:0] NREG_L  = 6'(NREG);
    localparam logic [4:0] OUT_IDX = 5'(OUT_REG);

    state_t          state, next_state;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [32];

    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1, src2, imm_i, imm_u, imm_b, imm_j;
    logic [XLEN-1:0] wr_data, next_pc;
    logic            illegal, ebreak, wr_en, taken, use_rs1, use_rs2, use_rd, bad_reg, trap;

    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = XLEN'($signed(a) < $signed(b));
            3'd3:    r = XLEN'(a < b);
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        logic t;
        case (f3)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd4:    t = ($signed(a) < $signed(b));
            3'd5:    t = ($signed(a) >= $signed(b));
            3'd6:    t = (a < b);
            default: t = (a >= b);
        endcase
        return t;
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign src1   = regs[rs1];
    assign src2   = regs[rs2];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        illegal = 1'b0;
        ebreak  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        taken   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        next_pc = ps + XLEN'(4);
        case (opcode)
            OP_R: begin
                {use_rs1, use_rs2, use_rd, wr_en} = 4'b1111;
                if (!(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))))
                    illegal = 1'b1;
                wr_data = alu(funct3, funct7[5], src1, src2);
            end
            OP_I: begin
                {use_rs1, use_rd, wr_en} = 3'b111;
                if (funct3 == 3'd1 && funct7 != 7'h00)
                    illegal = 1'b1;
                if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
                // Only the shift-right encoding uses bit 30 as a modifier; ADDI never subtracts.
                wr_data = alu(funct3, funct3 == 3'd5 && funct7[5], src1, imm_i);
            end
            OP_LUI: begin
                {use_rd, wr_en} = 2'b11;
                wr_data = imm_u;
            end
            OP_AUI: begin
                {use_rd, wr_en} = 2'b11;
                wr_data = ps + imm_u;
            end
            OP_JAL: begin
                {use_rd, wr_en, taken} = 3'b111;
                wr_data = ps + XLEN'(4);
                next_pc = ps + imm_j;
            end
            OP_JALR: begin
                {use_rs1, use_rd, wr_en, taken} = 4'b1111;
                illegal = (funct3 != 3'd0);
                wr_data = ps + XLEN'(4);
                next_pc = (src1 + imm_i) & ~XLEN'(1);
            end
            OP_BR: begin
                {use_rs1, use_rs2} = 2'b11;
                illegal = (funct3 == 3'd2 || funct3 == 3'd3);
                taken   = br_taken(funct3, src1, src2);
                if (taken)
                    next_pc = ps + imm_b;
            end
            OP_SYS: begin
                if (ir == 32'h0010_0073)
                    ebreak = 1'b1;
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bad_reg = (use_rs1 && {1'b0, rs1} >= NREG_L) || (use_rs2 && {1'b0, rs2} >= NREG_L)
                  || (use_rd && {1'b0, rd} >= NREG_L);
    assign trap    = illegal || bad_reg || (taken && next_pc[1]);

    always_ff @(posedge saat) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        buyruk_istek = 1'b0;
        case (state)
            FETCH: begin
                buyruk_istek = 1'b1;
                if (buyruk_gecerli)
                    next_state = EXEC;
            end
            EXEC: begin
                if (trap)
                    next_state = HATA;
                else if (ebreak)
                    next_state = DURDU;
                else
                    next_state = FETCH;
            end
            default: next_state = state;
        endcase
    end

    assign durdu  = (state == DURDU);
    assign hatali = (state == HATA);

    always_ff @(posedge saat) begin
        if (reset) begin
            ps          <= RESET_PC;
            ir          <= '0;
            tamamlanan  <= '0;
            yazmac_izle <= '0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else begin
            if (state == FETCH && buyruk_gecerli)
                ir <= buyruk;
            // Trapping instructions leave every piece of architectural state untouched.
            if (state == EXEC && !trap) begin
                tamamlanan <= tamamlanan + CNT_W'(1);
                if (!ebreak)
                    ps <= next_pc;
                if (wr_en && rd != 5'd0) begin
                    regs[rd] <= wr_data;
                    if (rd == OUT_IDX)
                        yazmac_izle <= wr_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_cok_cevrimli_islemci.sv
// Scoreboard bench for cok_cevrimli_islemci: directed and random instruction streams
// checked against an instruction-level reference model; plus an RV32E (NREG=16) build.
module tb_cok_cevrimli_islemci;
    logic saat = 1'b0;
    always #5 saat = ~saat;

    logic        reset, buyruk_istek, buyruk_gecerli, durdu, hatali;
    logic [31:0] ps, buyruk, tamamlanan;
    logic signed [31:0] yazmac_izle;

    logic        reset_e, istek_e, gecerli_e, durdu_e, hatali_e;
    logic [31:0] ps_e, buyruk_e, cnt_e;
    logic signed [31:0] izle_e;

    cok_cevrimli_islemci dut (
        .saat(saat), .reset(reset), .buyruk_istek(buyruk_istek), .ps(ps),
        .buyruk(buyruk), .buyruk_gecerli(buyruk_gecerli), .yazmac_izle(yazmac_izle),
        .tamamlanan(tamamlanan), .durdu(durdu), .hatali(hatali));

    cok_cevrimli_islemci #(.NREG(16)) dut_e (
        .saat(saat), .reset(reset_e), .buyruk_istek(istek_e), .ps(ps_e),
        .buyruk(buyruk_e), .buyruk_gecerli(gecerli_e), .yazmac_izle(izle_e),
        .tamamlanan(cnt_e), .durdu(durdu_e), .hatali(hatali_e));

    typedef struct {
        logic [31:0] ps;
        logic [31:0] izle;
        logic [31:0] cnt;
        logic        durdu;
        logic        hatali;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mr [32];
    logic [31:0] mpc, mcnt, w_izle;
    logic        mhalt, mtrap;
    int          mnreg = 32;
    logic [31:0] prog [20];
    bit          pend1 = 0, pend2 = 0;

    logic [9:0]  rtab [10] = '{{7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd1}, {7'h00, 3'd2},
                               {7'h00, 3'd3}, {7'h00, 3'd4}, {7'h00, 3'd5}, {7'h20, 3'd5},
                               {7'h00, 3'd6}, {7'h00, 3'd7}};
    logic [2:0]  btab [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6f};
    endfunction

    // Trap-free random instruction: aligned control-flow offsets, JALR only off x0.
    function automatic logic [31:0] gen_rand();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [9:0]  rf;
        logic [11:0] imm;
        int          k;
        k   = int'($urandom_range(0, 9));
        rd  = ($urandom_range(0, 1) == 1) ? 5'd10 : 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        if (k <= 3) begin
            rf = rtab[$urandom_range(0, 9)];
            return enc_r(rf[9:3], rs2, rs1, rf[2:0], rd);
        end else if (k <= 5) begin
            f3  = 3'($urandom_range(0, 7));
            imm = 12'($urandom());
            if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
            return enc_i(imm, rs1, f3, rd, 7'h13);
        end else if (k == 6) begin
            return enc_u(20'($urandom()), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
        end else if (k == 7) begin
            return enc_b((int'($urandom_range(0, 31)) - 16) * 4, rs2, rs1, btab[$urandom_range(0, 5)]);
        end else if (k == 8) begin
            return enc_j((int'($urandom_range(0, 63)) - 32) * 4, rd);
        end
        return enc_i(12'($urandom_range(0, 255) * 4), 5'd0, 3'd0, rd, 7'h67);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        mpc   = 32'h0;
        mcnt  = 32'h0;
        mhalt = 1'b0;
        mtrap = 1'b0;
    endtask

    // Instruction-level semantics straight from the ISA rules.
    task automatic model_exec(input logic [31:0] ins);
        logic [6:0]  op, f7;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, val, npc, immi, immu, immb, immj;
        bit          ill, ebr, wr, tkn, u1, u2, ud, badr;
        exp_t        e;
        op = ins[6:0];  rd = ins[11:7];  f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        a = mr[rs1]; b = mr[rs2];
        immi = {{20{ins[31]}}, ins[31:20]};
        immu = {ins[31:12], 12'b0};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ill = 0; ebr = 0; wr = 0; tkn = 0; u1 = 0; u2 = 0; ud = 0;
        val = 32'h0; npc = mpc + 32'd4;
        case (op)
            7'h33: begin
                u1 = 1; u2 = 1; ud = 1; wr = 1;
                case ({f7, f3})
                    {7'h00, 3'd0}: val = a + b;
                    {7'h20, 3'd0}: val = a - b;
                    {7'h00, 3'd1}: val = a << b[4:0];
                    {7'h00, 3'd2}: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    {7'h00, 3'd3}: val = (a < b) ? 32'd1 : 32'd0;
                    {7'h00, 3'd4}: val = a ^ b;
                    {7'h00, 3'd5}: val = a >> b[4:0];
                    {7'h20, 3'd5}: val = $unsigned($signed(a) >>> b[4:0]);
                    {7'h00, 3'd6}: val = a | b;
                    {7'h00, 3'd7}: val = a & b;
                    default:       ill = 1;
                endcase
            end
            7'h13: begin
                u1 = 1; ud = 1; wr = 1;
                case (f3)
                    3'd0: val = a + immi;
                    3'd2: val = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < immi) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ immi;
                    3'd6: val = a | immi;
                    3'd7: val = a & immi;
                    3'd1: if (f7 == 7'h00) val = a << ins[24:20]; else ill = 1;
                    default: begin
                        if (f7 == 7'h00)      val = a >> ins[24:20];
                        else if (f7 == 7'h20) val = $unsigned($signed(a) >>> ins[24:20]);
                        else                  ill = 1;
                    end
                endcase
            end
            7'h37: begin ud = 1; wr = 1; val = immu; end
            7'h17: begin ud = 1; wr = 1; val = mpc + immu; end
            7'h6f: begin ud = 1; wr = 1; tkn = 1; val = mpc + 32'd4; npc = mpc + immj; end
            7'h67: begin
                u1 = 1; ud = 1; wr = 1; tkn = 1; ill = (f3 != 3'd0);
                val = mpc + 32'd4; npc = (a + immi) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                u1 = 1; u2 = 1;
                case (f3)
                    3'd0: tkn = (a == b);
                    3'd1: tkn = (a != b);
                    3'd4: tkn = ($signed(a) < $signed(b));
                    3'd5: tkn = ($signed(a) >= $signed(b));
                    3'd6: tkn = (a < b);
                    3'd7: tkn = (a >= b);
                    default: ill = 1;
                endcase
                if (tkn) npc = mpc + immb;
            end
            7'h73: if (ins == 32'h0010_0073) ebr = 1; else ill = 1;
            default: ill = 1;
        endcase
        badr = (u1 && int'(rs1) >= mnreg) || (u2 && int'(rs2) >= mnreg) || (ud && int'(rd) >= mnreg);
        if (ill || badr || (tkn && npc[1])) begin
            mtrap = 1'b1;
        end else if (ebr) begin
            mcnt  = mcnt + 32'd1;
            mhalt = 1'b1;
        end else begin
            if (wr && rd != 5'd0) mr[rd] = val;
            mpc  = npc;
            mcnt = mcnt + 32'd1;
        end
        e = '{mpc, mr[10], mcnt, mhalt, mtrap};
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        buyruk_gecerli = 1'b0;
        @(posedge saat);
        @(posedge saat);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        repeat (3) @(posedge saat);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input int stalls, input bit push);
        int guard = 0;
        while (!buyruk_istek && guard < 50) begin
            @(posedge saat);
            #1 guard++;
        end
        tests++;
        if (!buyruk_istek) begin
            fails++;
            $display("FAIL fetch_timeout: buyruk_istek got 0 expected 1 at ps %h", ps);
            return;
        end
        repeat (stalls) begin
            @(posedge saat);
            #1;
        end
        buyruk = ins;
        buyruk_gecerli = 1'b1;
        if (push) model_exec(ins);
        @(posedge saat);
        #1 buyruk_gecerli = 1'b0;
        buyruk = $urandom();
    endtask

    // Monitor: an accepted fetch retires on the edge after next; compare on the negedge following it.
    always @(negedge saat) begin
        exp_t e;
        if (reset) begin
            pend1 = 0;
            pend2 = 0;
        end else begin
            if (pend2) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got retire with no expected entry, ps %h", ps);
                end else begin
                    e = sb.pop_front();
                    check("sb_ps", ps, e.ps);
                    check("sb_izle", yazmac_izle, e.izle);
                    check("sb_cnt", tamamlanan, e.cnt);
                    check("sb_durdu", {31'b0, durdu}, {31'b0, e.durdu});
                    check("sb_hatali", {31'b0, hatali}, {31'b0, e.hatali});
                end
            end
            pend2 = pend1;
            pend1 = buyruk_istek && buyruk_gecerli;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; buyruk = 32'h0; buyruk_gecerli = 1'b0;
        reset_e = 1'b1; buyruk_e = 32'h0; gecerli_e = 1'b0;
        model_reset();
        do_reset();

        // Reset state and idle fetch, then first instruction.
        repeat (5) begin @(posedge saat); #1; end
        check("rst_ps", ps, 32'h0);
        check("rst_istek", {31'b0, buyruk_istek}, 32'd1);
        check("rst_cnt", tamamlanan, 32'h0);
        check("rst_izle", yazmac_izle, 32'h0);
        check("rst_flags", {30'b0, durdu, hatali}, 32'h0);
        issue(32'hFFB0_0513, 0, 1);
        settle();
        check("addi_izle", yazmac_izle, 32'hFFFF_FFFB);
        check("addi_cnt", tamamlanan, 32'd1);
        check("addi_ps", ps, 32'd4);

        // ALU sweep.
        do_reset();
        issue(enc_u(20'h80000, 5'd1, 7'h37), 0, 1);
        issue(enc_i(12'd4, 5'd0, 3'd0, 5'd2, 7'h13), 0, 1);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd10), 0, 1);
        settle(); check("sra", yazmac_izle, 32'hF800_0000);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd10), 0, 1);
        settle(); check("srl", yazmac_izle, 32'h0800_0000);
        issue(enc_u(20'h00001, 5'd10, 7'h17), 0, 1);
        settle(); check("auipc", yazmac_izle, 32'h0000_1010);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd10), 1, 1);
        settle(); check("sltu", yazmac_izle, 32'd1);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd10), 2, 1);
        settle(); check("slt", yazmac_izle, 32'd0);
        issue(enc_u(20'h12345, 5'd10, 7'h37), 0, 1);
        settle(); check("lui", yazmac_izle, 32'h1234_5000);

        // Control flow.
        do_reset();
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'h13), 0, 1);
        for (int i = 0; i < 7; i++) issue(32'h0000_0013, 0, 1);
        issue(enc_b(-8, 5'd0, 5'd3, 3'd1), 0, 1);
        settle(); check("bne_ps", ps, 32'h18);
        issue(enc_i(12'h100, 5'd0, 3'd0, 5'd10, 7'h13), 0, 1);
        issue(enc_i(12'd1, 5'd10, 3'd0, 5'd10, 7'h67), 0, 1);
        settle(); check("jalr_ps", ps, 32'h100); check("jalr_rd", yazmac_izle, 32'h20);
        issue(enc_j(16, 5'd10), 0, 1);
        issue(enc_i(12'h100, 5'd0, 3'd0, 5'd10, 7'h13), 0, 1);
        issue(enc_i(12'd3, 5'd10, 3'd0, 5'd10, 7'h67), 0, 1);
        settle(); check("jalr_mis", {31'b0, hatali}, 32'd1);
        check("jalr_mis_ps", ps, 32'h114);

        // Wait states: same program with and without fetch stalls.
        for (int i = 0; i < 20; i++) prog[i] = gen_rand();
        do_reset();
        for (int i = 0; i < 20; i++) issue(prog[i], 0, 1);
        settle();
        w_izle = mr[10];
        do_reset();
        for (int i = 0; i < 20; i++) issue(prog[i], int'($urandom_range(1, 3)), 1);
        settle();
        check("ws_izle", yazmac_izle, w_izle);
        check("ws_cnt", tamamlanan, 32'd20);

        // Halt and traps.
        do_reset();
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd10, 7'h13), 0, 1);
        issue(32'h0010_0073, 0, 1);
        settle();
        check("ebreak_durdu", {31'b0, durdu}, 32'd1);
        check("ebreak_istek", {31'b0, buyruk_istek}, 32'd0);
        check("ebreak_cnt", tamamlanan, 32'd2);
        buyruk_gecerli = 1'b1; buyruk = 32'h0000_0013;
        repeat (4) begin @(posedge saat); #1; end
        buyruk_gecerli = 1'b0;
        check("halt_ps", ps, 32'd4);
        check("halt_cnt", tamamlanan, 32'd2);
        check("halt_sticky", {30'b0, durdu, hatali}, 32'd2);
        do_reset();
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd10, 7'h13), 0, 1);
        issue(32'h0000_2503, 1, 1);
        settle();
        check("load_hatali", {31'b0, hatali}, 32'd1);
        check("load_izle", yazmac_izle, 32'd7);
        check("load_istek", {31'b0, buyruk_istek}, 32'd0);
        do_reset();
        issue(enc_b(6, 5'd0, 5'd0, 3'd0), 0, 1);
        settle();
        check("beq_mis", {31'b0, hatali}, 32'd1);
        check("beq_mis_ps", ps, 32'h0);

        // Reset during EXEC discards the instruction.
        do_reset();
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 0, 1);
        issue(enc_i(12'd6, 5'd0, 3'd0, 5'd2, 7'h13), 0, 1);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10), 0, 0);
        reset = 1'b1;
        @(posedge saat);
        @(posedge saat);
        #1 reset = 1'b0;
        model_reset();
        check("midrst_izle", yazmac_izle, 32'h0);
        check("midrst_ps", ps, 32'h0);
        check("midrst_cnt", tamamlanan, 32'h0);
        check("midrst_istek", {31'b0, buyruk_istek}, 32'd1);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10), 0, 1);
        settle();

        // Random streams.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 30; i++) issue(gen_rand(), int'($urandom_range(0, 2)), 1);
            settle();
        end

        // RV32E build: x20 is out of range.
        @(posedge saat);
        #1 reset_e = 1'b0;
        repeat (2) begin @(posedge saat); #1; end
        check("e_istek", {31'b0, istek_e}, 32'd1);
        buyruk_e = enc_i(12'd9, 5'd0, 3'd0, 5'd10, 7'h13); gecerli_e = 1'b1;
        @(posedge saat);
        #1 gecerli_e = 1'b0;
        repeat (2) begin @(posedge saat); #1; end
        check("e_addi", izle_e, 32'd9);
        buyruk_e = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd20); gecerli_e = 1'b1;
        @(posedge saat);
        #1 gecerli_e = 1'b0;
        repeat (3) begin @(posedge saat); #1; end
        check("e_hatali", {31'b0, hatali_e}, 32'd1);
        check("e_cnt", cnt_e, 32'd1);
        check("e_ps", ps_e, 32'd4);
        check("e_izle", izle_e, 32'd9);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
